// File: rtl/wb_mon_pkg.sv
// wb_mon_pkg: shared constants for the Wishbone slave-side protocol monitor.
// Error-bit indices are used by the monitor and by anything that decodes o_err.
package wb_mon_pkg;

   localparam int ERR_NOREQ_ACK   = 0;  // ack/err with nothing outstanding
   localparam int ERR_ACK_AND_ERR = 1;  // ack and err in the same cycle
   localparam int ERR_STALL_CHG   = 2;  // request changed while stalled
   localparam int ERR_STB_NO_CYC  = 3;  // stb without cyc
   localparam int ERR_DISCONT     = 4;  // stb gap or we change inside one cyc
   localparam int ERR_TIMEOUT     = 5;  // stall run or ack wait too long
   localparam int ERR_OVERFLOW    = 6;  // request counter hit its ceiling
   localparam int ERR_IDLE_CYC    = 7;  // cyc held idle with nothing outstanding
   localparam int ERR_W           = 8;

   // Width of the run-length timers; they saturate, so this only bounds the limit.
   localparam int TIMER_W         = 16;

   typedef logic [ERR_W-1:0] err_vec_t;

endpackage

// File: rtl/wb_mon_timer.sv
// wb_mon_timer: saturating run-length counter with a limit compare.
// r_count holds the number of earlier consecutive active cycles, so the run
// including the current cycle is r_count+1; o_over fires when that exceeds LIMIT.
// LIMIT = 0 disables the compare.
module wb_mon_timer
   import wb_mon_pkg::*;
#(
   parameter int unsigned LIMIT = 0,
   parameter int unsigned W     = TIMER_W
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_active,
   input  logic i_restart,
   output logic o_over
);

   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] r_count;

   // Count consecutive active cycles; any inactive or restart cycle starts over.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count <= '0;
      end else if (!i_active || i_restart) begin
         r_count <= '0;
      end else if (r_count != '1) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_over = (LIMIT != 0) && i_active && (r_count >= LIM);

endmodule

// File: rtl/wb_slave_monitor.sv
// wb_slave_monitor: passive Wishbone B4 pipelined protocol monitor (slave side).
// Counts accepted requests and responses within a cyc, reports outstanding
// transactions and latches protocol violations into sticky o_err bits.
// Define WB_MON_ASSERT_EN to add simulation-only assertions that name each
// violated rule in the cycle its o_err bit first sets.
module wb_slave_monitor
   import wb_mon_pkg::*;
#(
   parameter int          AW                   = 30,
   parameter int          DW                   = 32,
   parameter int          F_LGDEPTH            = 4,
   parameter int unsigned F_MAX_STALL          = 0,
   parameter int unsigned F_MAX_ACK_DELAY      = 0,
   parameter bit          F_OPT_RMW_BUS_OPTION = 1'b1,
   parameter bit          F_OPT_DISCONTINUOUS  = 1'b1,
   parameter bit          F_OPT_MINCLOCK_DELAY = 1'b1
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_wb_cyc,
   input  logic                 i_wb_stb,
   input  logic                 i_wb_we,
   input  logic [AW-1:0]        i_wb_addr,
   input  logic [DW-1:0]        i_wb_data,
   input  logic [DW/8-1:0]      i_wb_sel,
   input  logic                 i_wb_ack,
   input  logic                 i_wb_stall,
   input  logic [DW-1:0]        i_wb_idata,
   input  logic                 i_wb_err,
   output logic [F_LGDEPTH-1:0] o_nreqs,
   output logic [F_LGDEPTH-1:0] o_nacks,
   output logic [F_LGDEPTH-1:0] o_outstanding,
   output logic [ERR_W-1:0]     o_err
);

   localparam logic [F_LGDEPTH-1:0] CNT_MAX = '1;

   logic [F_LGDEPTH-1:0] r_nreqs, r_nacks;
   logic [F_LGDEPTH-1:0] w_nreqs_next, w_nacks_next, w_outstanding;
   logic                 w_req, w_resp;
   logic                 r_past_cyc, r_past_stb, r_past_stall, r_past_we, r_past_err;
   logic                 r_seen_stb, r_last_we, r_armed;
   logic [AW-1:0]        r_past_addr;
   logic [DW-1:0]        r_past_data;
   logic [DW/8-1:0]      r_past_sel;
   err_vec_t             r_err, w_viol;
   logic                 w_stall_active, w_stall_over, w_ack_active, w_ack_over;
   logic                 w_req_changed;
   logic                 w_unused;

   // Read data is only observed; nothing in the monitor depends on it.
   assign w_unused = ^i_wb_idata;

   assign w_req         = i_wb_cyc & i_wb_stb & ~i_wb_stall;
   assign w_resp        = i_wb_cyc & (i_wb_ack | i_wb_err);
   assign w_outstanding = r_nreqs - r_nacks;

   // Next counter values: cleared outside a cyc or the cycle after an err, else saturating.
   always_comb begin
      w_nreqs_next = r_nreqs;
      w_nacks_next = r_nacks;
      if (!i_wb_cyc || r_past_err) begin
         w_nreqs_next = '0;
         w_nacks_next = '0;
      end else begin
         if (w_req && (r_nreqs != CNT_MAX)) w_nreqs_next = r_nreqs + 1'b1;
         if (w_resp && (r_nacks != CNT_MAX)) w_nacks_next = r_nacks + 1'b1;
      end
   end

   // Consecutive stall cycles while a request is presented.
   assign w_stall_active = i_wb_cyc & i_wb_stb & i_wb_stall;
   wb_mon_timer #(.LIMIT(F_MAX_STALL)) u_stall_timer (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_active  (w_stall_active),
      .i_restart (1'b0),
      .o_over    (w_stall_over)
   );

   // Wait of the oldest outstanding request; every response hands over to the next one.
   assign w_ack_active = i_wb_cyc & (w_outstanding != '0);
   wb_mon_timer #(.LIMIT(F_MAX_ACK_DELAY)) u_ack_timer (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_active  (w_ack_active),
      .i_restart (w_resp),
      .o_over    (w_ack_over)
   );

   assign w_req_changed = (i_wb_addr != r_past_addr) || (i_wb_we != r_past_we) ||
                          (i_wb_sel != r_past_sel) || (i_wb_we && (i_wb_data != r_past_data));

   // Combinational violation detection for this cycle.
   always_comb begin
      w_viol = '0;
      w_viol[ERR_NOREQ_ACK]   = i_wb_cyc && (i_wb_ack || i_wb_err) && (w_outstanding == '0) &&
                                (F_OPT_MINCLOCK_DELAY || !w_req);
      w_viol[ERR_ACK_AND_ERR] = i_wb_cyc && i_wb_ack && i_wb_err;
      w_viol[ERR_STALL_CHG]   = i_wb_cyc && i_wb_stb && r_past_cyc && r_past_stb &&
                                r_past_stall && w_req_changed;
      w_viol[ERR_STB_NO_CYC]  = i_wb_stb && !i_wb_cyc;
      w_viol[ERR_DISCONT]     = i_wb_cyc && i_wb_stb && r_seen_stb &&
                                ((!F_OPT_DISCONTINUOUS && !r_past_stb) || (i_wb_we != r_last_we));
      w_viol[ERR_TIMEOUT]     = w_stall_over || w_ack_over;
      w_viol[ERR_OVERFLOW]    = i_wb_cyc && (w_nreqs_next == CNT_MAX);
      w_viol[ERR_IDLE_CYC]    = !F_OPT_RMW_BUS_OPTION && i_wb_cyc && !i_wb_stb &&
                                r_past_cyc && (w_outstanding == '0);
   end

   // Request/response counters.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_nreqs <= '0;
         r_nacks <= '0;
      end else begin
         r_nreqs <= w_nreqs_next;
         r_nacks <= w_nacks_next;
      end
   end

   // Past-cycle bus state used by the stall, gap and idle checks.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_past_cyc   <= 1'b0;
         r_past_stb   <= 1'b0;
         r_past_stall <= 1'b0;
         r_past_we    <= 1'b0;
         r_past_err   <= 1'b0;
         r_past_addr  <= '0;
         r_past_data  <= '0;
         r_past_sel   <= '0;
         r_seen_stb   <= 1'b0;
         r_last_we    <= 1'b0;
      end else begin
         r_past_cyc   <= i_wb_cyc;
         r_past_stb   <= i_wb_stb;
         r_past_stall <= i_wb_stall;
         r_past_we    <= i_wb_we;
         r_past_err   <= i_wb_cyc & i_wb_err;
         r_past_addr  <= i_wb_addr;
         r_past_data  <= i_wb_data;
         r_past_sel   <= i_wb_sel;
         if (!i_wb_cyc) begin
            r_seen_stb <= 1'b0;
         end else if (i_wb_stb) begin
            r_seen_stb <= 1'b1;
            r_last_we  <= i_wb_we;
         end
      end
   end

   // Sticky error flags; the first cycle after reset release is never flagged.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_armed <= 1'b0;
         r_err   <= '0;
      end else begin
         r_armed <= 1'b1;
         if (r_armed) r_err <= r_err | w_viol;
      end
   end

`ifdef WB_MON_ASSERT_EN
   err_vec_t w_new_err;
   assign w_new_err = r_armed ? (w_viol & ~r_err) : '0;

   // Name each rule in the cycle its sticky flag is first raised.
   always @(posedge i_clk) begin
      if (i_reset_n) begin
         a_noreq_ack: assert (!w_new_err[ERR_NOREQ_ACK])   else $error("wb_mon: ack/err with no request outstanding");
         a_ack_err:   assert (!w_new_err[ERR_ACK_AND_ERR]) else $error("wb_mon: ack and err in the same cycle");
         a_stall_chg: assert (!w_new_err[ERR_STALL_CHG])   else $error("wb_mon: request changed while stalled");
         a_stb_nocyc: assert (!w_new_err[ERR_STB_NO_CYC])  else $error("wb_mon: stb asserted without cyc");
         a_discont:   assert (!w_new_err[ERR_DISCONT])     else $error("wb_mon: stb gap or we change inside one cyc");
         a_timeout:   assert (!w_new_err[ERR_TIMEOUT])     else $error("wb_mon: stall run or ack delay limit exceeded");
         a_overflow:  assert (!w_new_err[ERR_OVERFLOW])    else $error("wb_mon: request counter overflow");
         a_idle_cyc:  assert (!w_new_err[ERR_IDLE_CYC])    else $error("wb_mon: cyc idle with nothing outstanding");
      end
   end
`endif

   assign o_nreqs       = r_nreqs;
   assign o_nacks       = r_nacks;
   assign o_outstanding = w_outstanding;
   assign o_err         = r_err;

endmodule

// File: tb/tb_wb_slave_monitor.sv
// tb_wb_slave_monitor: table-driven check of wb_slave_monitor.
// Two monitors watch the same bus: one with default options and one strict
// build (stall limit 1, ack delay limit 2, no RMW idle, no stb gaps, same-cycle
// ack allowed). Expected values are pushed to a queue as each vector is driven
// and popped after the clock edge.
module tb_wb_slave_monitor;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc, stb, we, ack, err, stall;
   logic [29:0] addr;
   logic [31:0] data, idata;
   logic [3:0]  sel;

   logic [3:0]  d_nreqs, d_nacks, d_out;
   logic [7:0]  d_err;
   logic [3:0]  s_nreqs, s_nacks, s_out;
   logic [7:0]  s_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wb_slave_monitor dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
      .i_wb_data(data), .i_wb_sel(sel), .i_wb_ack(ack), .i_wb_stall(stall),
      .i_wb_idata(idata), .i_wb_err(err),
      .o_nreqs(d_nreqs), .o_nacks(d_nacks), .o_outstanding(d_out), .o_err(d_err)
   );

   wb_slave_monitor #(
      .F_MAX_STALL(1), .F_MAX_ACK_DELAY(2), .F_OPT_RMW_BUS_OPTION(1'b0),
      .F_OPT_DISCONTINUOUS(1'b0), .F_OPT_MINCLOCK_DELAY(1'b0)
   ) dut_s (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
      .i_wb_data(data), .i_wb_sel(sel), .i_wb_ack(ack), .i_wb_stall(stall),
      .i_wb_idata(idata), .i_wb_err(err),
      .o_nreqs(s_nreqs), .o_nacks(s_nacks), .o_outstanding(s_out), .o_err(s_err)
   );

   typedef struct {
      string       name;
      logic        cyc, stb, we;
      logic [29:0] addr;
      logic        ack, err, stall;
      logic [3:0]  e_nreqs, e_nacks, e_out;
      logic [7:0]  e_err, e_err_s;
   } vec_t;

   vec_t sb_q[$];
   vec_t tbl[23];

   function automatic vec_t mk(input string n, input logic c, input logic s, input logic w,
                               input logic [29:0] a, input logic ak, input logic er, input logic st,
                               input logic [3:0] nq, input logic [3:0] na, input logic [3:0] no,
                               input logic [7:0] e, input logic [7:0] es);
      vec_t v;
      v.name = n; v.cyc = c; v.stb = s; v.we = w; v.addr = a;
      v.ack = ak; v.err = er; v.stall = st;
      v.e_nreqs = nq; v.e_nacks = na; v.e_out = no; v.e_err = e; v.e_err_s = es;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, act, exp);
      end
   endtask

   task automatic idle_bus();
      cyc = L; stb = L; we = L; addr = '0; ack = L; err = L; stall = L;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".nreqs"},   {4'h0, d_nreqs}, 8'h00);
      chk({tag, ".nacks"},   {4'h0, d_nacks}, 8'h00);
      chk({tag, ".out"},     {4'h0, d_out},   8'h00);
      chk({tag, ".err"},     d_err,           8'h00);
      chk({tag, ".s_nreqs"}, {4'h0, s_nreqs}, 8'h00);
      chk({tag, ".s_out"},   {4'h0, s_out},   8'h00);
      chk({tag, ".s_err"},   s_err,           8'h00);
   endtask

   task automatic step(input vec_t v);
      vec_t e;
      cyc = v.cyc; stb = v.stb; we = v.we; addr = v.addr;
      ack = v.ack; err = v.err; stall = v.stall;
      sb_q.push_back(v);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      $display("[TB] %-16s cyc=%b stb=%b we=%b ack=%b err=%b stall=%b -> nreqs=%0d nacks=%0d out=%0d err=%02h strict_err=%02h",
               e.name, e.cyc, e.stb, e.we, e.ack, e.err, e.stall, d_nreqs, d_nacks, d_out, d_err, s_err);
      chk({e.name, ".nreqs"},   {4'h0, d_nreqs}, {4'h0, e.e_nreqs});
      chk({e.name, ".nacks"},   {4'h0, d_nacks}, {4'h0, e.e_nacks});
      chk({e.name, ".out"},     {4'h0, d_out},   {4'h0, e.e_out});
      chk({e.name, ".err"},     d_err,           e.e_err);
      chk({e.name, ".s_nreqs"}, {4'h0, s_nreqs}, {4'h0, e.e_nreqs});
      chk({e.name, ".s_err"},   s_err,           e.e_err_s);
   endtask

   task automatic do_reset(input logic hold_stb);
      rst_n = 1'b0;
      idle_bus();
      stb = hold_stb;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      data  = 32'hDEADBEEF;
      sel   = 4'hF;
      idata = 32'h0;
      rst_n = 1'b0;
      idle_bus();

      //            name            cyc stb we addr    ack err stl nrq  nak  out   err    strict
      tbl[0]  = mk("idle",          L, L, L, 30'h00, L, L, L, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00);
      tbl[1]  = mk("wr_req",        H, H, H, 30'h10, L, L, L, 4'd1, 4'd0, 4'd1, 8'h00, 8'h00);
      tbl[2]  = mk("wr_ack",        H, L, H, 30'h10, H, L, L, 4'd1, 4'd1, 4'd0, 8'h00, 8'h00);
      tbl[3]  = mk("wr_end",        L, L, L, 30'h00, L, L, L, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00);
      tbl[4]  = mk("p1_beat0",      H, H, L, 30'h20, L, L, L, 4'd1, 4'd0, 4'd1, 8'h00, 8'h00);
      tbl[5]  = mk("p1_beat1",      H, H, L, 30'h21, H, L, L, 4'd2, 4'd1, 4'd1, 8'h00, 8'h00);
      tbl[6]  = mk("p1_beat2",      H, H, L, 30'h22, H, L, L, 4'd3, 4'd2, 4'd1, 8'h00, 8'h00);
      tbl[7]  = mk("p1_ack3",       H, L, L, 30'h22, H, L, L, 4'd3, 4'd3, 4'd0, 8'h00, 8'h00);
      tbl[8]  = mk("p1_end",        L, L, L, 30'h00, L, L, L, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00);
      tbl[9]  = mk("p2_beat0",      H, H, L, 30'h30, L, L, L, 4'd1, 4'd0, 4'd1, 8'h00, 8'h00);
      tbl[10] = mk("p2_beat1",      H, H, L, 30'h31, L, L, L, 4'd2, 4'd0, 4'd2, 8'h00, 8'h00);
      tbl[11] = mk("p2_beat2",      H, H, L, 30'h32, H, L, L, 4'd3, 4'd1, 4'd2, 8'h00, 8'h00);
      tbl[12] = mk("p2_ack2",       H, L, L, 30'h32, H, L, L, 4'd3, 4'd2, 4'd1, 8'h00, 8'h00);
      tbl[13] = mk("p2_ack3",       H, L, L, 30'h32, H, L, L, 4'd3, 4'd3, 4'd0, 8'h00, 8'h00);
      tbl[14] = mk("p2_end",        L, L, L, 30'h00, L, L, L, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00);
      tbl[15] = mk("same_cyc_ack",  H, H, L, 30'h40, H, L, L, 4'd1, 4'd1, 4'd0, 8'h01, 8'h00);
      tbl[16] = mk("idle2",         L, L, L, 30'h00, L, L, L, 4'd0, 4'd0, 4'd0, 8'h01, 8'h00);
      tbl[17] = mk("req_for_err",   H, H, L, 30'h44, L, L, L, 4'd1, 4'd0, 4'd1, 8'h01, 8'h00);
      tbl[18] = mk("ack_and_err",   H, L, L, 30'h44, H, H, L, 4'd1, 4'd1, 4'd0, 8'h03, 8'h02);
      tbl[19] = mk("post_err",      H, L, L, 30'h44, L, L, L, 4'd0, 4'd0, 4'd0, 8'h03, 8'h82);
      tbl[20] = mk("idle3",         L, L, L, 30'h00, L, L, L, 4'd0, 4'd0, 4'd0, 8'h03, 8'h82);
      tbl[21] = mk("stb_no_cyc",    L, H, L, 30'h00, L, L, L, 4'd0, 4'd0, 4'd0, 8'h0B, 8'h8A);
      tbl[22] = mk("idle4",         L, L, L, 30'h00, L, L, L, 4'd0, 4'd0, 4'd0, 8'h0B, 8'h8A);

      // Reset state, observed after a clock edge with reset held low.
      @(posedge clk);
      #1;
      check_zero("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) step(tbl[i]);

      // Stalled request whose address moves; strict build also trips the stall limit.
      do_reset(L);
      step(mk("stall0",          H, H, L, 30'h10, L, L, H, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00));
      step(mk("stall1_addr_chg", H, H, L, 30'h14, L, L, H, 4'd0, 4'd0, 4'd0, 8'h04, 8'h24));
      step(mk("stall_release",   H, H, L, 30'h14, L, L, L, 4'd1, 4'd0, 4'd1, 8'h04, 8'h24));
      step(mk("stall_end",       L, L, L, 30'h00, L, L, L, 4'd0, 4'd0, 4'd0, 8'h04, 8'h24));

      // Fifteen unanswered requests reach the counter ceiling; strict ack timer expires at beat 4.
      do_reset(L);
      for (int i = 1; i <= 15; i++) begin
         step(mk("ovf_req", H, H, L, 30'(i), L, L, L, 4'(i), 4'd0, 4'(i),
                 (i == 15) ? 8'h40 : 8'h00,
                 ((i >= 4) ? 8'h20 : 8'h00) | ((i == 15) ? 8'h40 : 8'h00)));
      end
      step(mk("ovf_cyc_drop", L, L, L, 30'h00, L, L, L, 4'd0, 4'd0, 4'd0, 8'h40, 8'h60));

      // we flips between beats of one cyc.
      do_reset(L);
      step(mk("we_beat0", H, H, L, 30'h60, L, L, L, 4'd1, 4'd0, 4'd1, 8'h00, 8'h00));
      step(mk("we_beat1", H, H, H, 30'h61, L, L, L, 4'd2, 4'd0, 4'd2, 8'h10, 8'h10));
      step(mk("we_end",   L, L, L, 30'h00, L, L, L, 4'd0, 4'd0, 4'd0, 8'h10, 8'h10));

      // stb drops and re-rises inside one cyc: only the strict build objects.
      do_reset(L);
      step(mk("dc_beat0", H, H, L, 30'h70, L, L, L, 4'd1, 4'd0, 4'd1, 8'h00, 8'h00));
      step(mk("dc_gap",   H, L, L, 30'h70, H, L, L, 4'd1, 4'd1, 4'd0, 8'h00, 8'h00));
      step(mk("dc_beat1", H, H, L, 30'h71, L, L, L, 4'd2, 4'd1, 4'd1, 8'h00, 8'h10));
      step(mk("dc_end",   L, L, L, 30'h00, L, L, L, 4'd0, 4'd0, 4'd0, 8'h00, 8'h10));

      // A violation present in the first cycle after reset release is ignored, the next is not.
      do_reset(H);
      chk("first_cycle.err",   d_err, 8'h00);
      chk("first_cycle.s_err", s_err, 8'h00);
      step(mk("stb_nocyc_armed", L, H, L, 30'h00, L, L, L, 4'd0, 4'd0, 4'd0, 8'h08, 8'h08));

      // Asynchronous reset mid-burst clears everything without a clock edge.
      do_reset(L);
      step(mk("pre_stb_nocyc", L, H, L, 30'h00, L, L, L, 4'd0, 4'd0, 4'd0, 8'h08, 8'h08));
      step(mk("burst0",        H, H, L, 30'h50, L, L, L, 4'd1, 4'd0, 4'd1, 8'h08, 8'h08));
      step(mk("burst1",        H, H, L, 30'h51, L, L, L, 4'd2, 4'd0, 4'd2, 8'h08, 8'h08));
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      idle_bus();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
